// File: rtl/ffl_lockout_latch.sv
// Buzzer lockout: synchronises contestant buttons, captures the first valid press,
// masks buttons held at arm, reports ties and measures response time.
module ffl_lockout_latch #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned IDX_W       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  input  logic                arm,
  input  logic                clear,
  input  logic [TIMER_W-1:0]  timeout_cycles,
  output logic [1:0]          state,
  output logic                winner_valid,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [CHANNELS-1:0] winner_onehot,
  output logic                tie,
  output logic [CHANNELS-1:0] foul_mask,
  output logic [TIMER_W-1:0]  elapsed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e                                   state_q, state_d;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0]     sync_q, sync_d;
  logic [CHANNELS-1:0]                      bd_q, bd_d;
  logic                                     winner_valid_q, winner_valid_d;
  logic [IDX_W-1:0]                         winner_idx_q, winner_idx_d;
  logic [CHANNELS-1:0]                      winner_onehot_q, winner_onehot_d;
  logic                                     tie_q, tie_d;
  logic [CHANNELS-1:0]                      foul_mask_q, foul_mask_d;
  logic [TIMER_W-1:0]                       elapsed_q, elapsed_d;

  logic [CHANNELS-1:0] bs;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] first_onehot;
  logic [IDX_W-1:0]    first_idx;
  logic                multi_press;
  logic                timeout_hit;

  // Synchroniser chain plus one delay stage for edge detection.
  always_comb begin
    sync_d[0] = btn;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign bs   = sync_q[SYNC_STAGES-1];
  assign bd_d = bs;
  assign rise = bs & ~bd_q;
  assign elig = rise & ~foul_mask_q;

  // Lowest set bit wins; any further bit means a tie.
  assign first_onehot = elig & (~elig + CHANNELS'(1));
  assign multi_press  = |(elig & (elig - CHANNELS'(1)));

  always_comb begin
    first_idx = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (elig[i]) first_idx = IDX_W'(i);
    end
  end

  assign timeout_hit = (timeout_cycles != '0) &&
                       (((TIMER_W+1)'(elapsed_q) + (TIMER_W+1)'(1)) == (TIMER_W+1)'(timeout_cycles));

  always_comb begin
    state_d         = state_q;
    winner_valid_d  = winner_valid_q;
    winner_idx_d    = winner_idx_q;
    winner_onehot_d = winner_onehot_q;
    tie_d           = tie_q;
    foul_mask_d     = foul_mask_q;
    elapsed_d       = elapsed_q;

    case (state_q)
      ST_IDLE: begin
        winner_valid_d  = 1'b0;
        winner_idx_d    = '0;
        winner_onehot_d = '0;
        tie_d           = 1'b0;
        foul_mask_d     = '0;
        if (arm) begin
          state_d     = ST_ARMED;
          elapsed_d   = '0;
          foul_mask_d = bs;
        end
      end
      ST_ARMED: begin
        foul_mask_d = foul_mask_q & bs;
        if (elig != '0) begin
          state_d         = ST_LOCKED;
          winner_valid_d  = 1'b1;
          winner_idx_d    = first_idx;
          winner_onehot_d = first_onehot;
          tie_d           = multi_press;
        end else if (timeout_hit) begin
          state_d   = ST_TIMEOUT;
          elapsed_d = timeout_cycles;
        end else if (elapsed_q != '1) begin
          elapsed_d = elapsed_q + TIMER_W'(1);
        end
      end
      default: ;
    endcase

    // Clear dominates arm and everything else; elapsed is kept for readout.
    if (clear) begin
      state_d         = ST_IDLE;
      winner_valid_d  = 1'b0;
      winner_idx_d    = '0;
      winner_onehot_d = '0;
      tie_d           = 1'b0;
      foul_mask_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      sync_q          <= '0;
      bd_q            <= '0;
      winner_valid_q  <= 1'b0;
      winner_idx_q    <= '0;
      winner_onehot_q <= '0;
      tie_q           <= 1'b0;
      foul_mask_q     <= '0;
      elapsed_q       <= '0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      bd_q            <= bd_d;
      winner_valid_q  <= winner_valid_d;
      winner_idx_q    <= winner_idx_d;
      winner_onehot_q <= winner_onehot_d;
      tie_q           <= tie_d;
      foul_mask_q     <= foul_mask_d;
      elapsed_q       <= elapsed_d;
    end
  end

  assign state         = state_q;
  assign winner_valid  = winner_valid_q;
  assign winner_idx    = winner_idx_q;
  assign winner_onehot = winner_onehot_q;
  assign tie           = tie_q;
  assign foul_mask     = foul_mask_q;
  assign elapsed       = elapsed_q;

endmodule

// File: tb/tb_ffl_lockout_latch.sv
// Self-checking bench for ffl_lockout_latch: directed scenarios plus randomized
// rounds predicted from press/timeout edge arithmetic.
module tb_ffl_lockout_latch;

  localparam int unsigned SS4  = 2;
  localparam int unsigned SS16 = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_LOCKED = 2'd2, S_TIMEOUT = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  btn4 = '0;
  logic        arm4 = 1'b0, clear4 = 1'b0;
  logic [15:0] to4 = '0;
  logic [1:0]  state4;
  logic        wv4, tie4;
  logic [1:0]  wi4;
  logic [3:0]  wo4, fm4;
  logic [15:0] el4;

  logic [15:0] btn16 = '0;
  logic        arm16 = 1'b0, clear16 = 1'b0;
  logic [15:0] to16 = '0;
  logic [1:0]  state16;
  logic        wv16, tie16;
  logic [3:0]  wi16;
  logic [15:0] wo16, fm16, el16;

  ffl_lockout_latch #(.CHANNELS(4), .SYNC_STAGES(SS4), .TIMER_W(16)) dut4 (
    .clk(clk), .rst(rst), .btn(btn4), .arm(arm4), .clear(clear4), .timeout_cycles(to4),
    .state(state4), .winner_valid(wv4), .winner_idx(wi4), .winner_onehot(wo4),
    .tie(tie4), .foul_mask(fm4), .elapsed(el4));

  ffl_lockout_latch #(.CHANNELS(16), .SYNC_STAGES(SS16), .TIMER_W(16)) dut16 (
    .clk(clk), .rst(rst), .btn(btn16), .arm(arm16), .clear(clear16), .timeout_cycles(to16),
    .state(state16), .winner_valid(wv16), .winner_idx(wi16), .winner_onehot(wo16),
    .tie(tie16), .foul_mask(fm16), .elapsed(el16));

  wire [29:0] obs4  = {state4, wv4, wi4, wo4, tie4, fm4, el4};
  wire [55:0] obs16 = {state16, wv16, wi16, wo16, tie16, fm16, el16};

  int errors = 0;
  int checks = 0;

  function automatic logic [29:0] exp4(input logic [1:0] st, input logic v, input logic [1:0] idx,
                                       input logic [3:0] oh, input logic t, input logic [3:0] fm,
                                       input int el);
    return {st, v, idx, oh, t, fm, 16'(el)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_4();
    arm4 = 1'b1; tick(); arm4 = 1'b0;
  endtask

  task automatic end_round_4();
    btn4 = '0; clear4 = 1'b1; tick(); clear4 = 1'b0;
    for (int i = 0; i < int'(SS4) + 2; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (obs4 !== 30'd0) begin errors++; $display("FAIL reset4 got=%h want=0", obs4); end
    checks++; if (obs16 !== 56'd0) begin errors++; $display("FAIL reset16 got=%h want=0", obs16); end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_lock();
    int d;
    d = 10 - int'(SS4);
    arm_4();
    checks++; if (obs4 !== exp4(S_ARMED, 0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL arm got=%h want=%h", obs4, exp4(S_ARMED,0,0,0,0,0,0)); end
    for (int r = 0; r < d; r++) tick();
    btn4 = 4'b0100;
    for (int r = 0; r < int'(SS4); r++) tick();
    checks++; if (state4 !== S_ARMED) begin errors++; $display("FAIL basic_prelock state=%0d want=%0d", state4, S_ARMED); end
    tick();
    checks++; if (obs4 !== exp4(S_LOCKED, 1, 2, 4'b0100, 0, 0, 10)) begin errors++; $display("FAIL basic_lock got=%h want=%h", obs4, exp4(S_LOCKED,1,2,4'b0100,0,0,10)); end
    btn4 = 4'b0101;
    for (int r = 0; r < 5; r++) tick();
    checks++; if (obs4 !== exp4(S_LOCKED, 1, 2, 4'b0100, 0, 0, 10)) begin errors++; $display("FAIL basic_hold got=%h want=%h", obs4, exp4(S_LOCKED,1,2,4'b0100,0,0,10)); end
    end_round_4();
  endtask

  task automatic test_tie();
    arm_4();
    for (int r = 0; r < 3; r++) tick();
    btn4 = 4'b1010;
    for (int r = 0; r <= int'(SS4); r++) tick();
    checks++; if (obs4 !== exp4(S_LOCKED, 1, 1, 4'b0010, 1, 0, 3 + int'(SS4))) begin errors++; $display("FAIL tie got=%h want=%h", obs4, exp4(S_LOCKED,1,1,4'b0010,1,0,3+int'(SS4))); end
    clear4 = 1'b1; tick(); clear4 = 1'b0;
    checks++; if (obs4 !== exp4(S_IDLE, 0, 0, 0, 0, 0, 3 + int'(SS4))) begin errors++; $display("FAIL tie_clear got=%h want=%h", obs4, exp4(S_IDLE,0,0,0,0,0,3+int'(SS4))); end
    end_round_4();
  endtask

  task automatic test_foul();
    int el;
    btn4 = 4'b0001;
    for (int r = 0; r < int'(SS4) + 2; r++) tick();
    arm_4();
    checks++; if (obs4 !== exp4(S_ARMED, 0, 0, 0, 0, 4'b0001, 0)) begin errors++; $display("FAIL foul_arm got=%h want=%h", obs4, exp4(S_ARMED,0,0,0,0,4'b0001,0)); end
    for (int r = 0; r < 10; r++) tick();
    checks++; if (obs4 !== exp4(S_ARMED, 0, 0, 0, 0, 4'b0001, 10)) begin errors++; $display("FAIL foul_held got=%h want=%h", obs4, exp4(S_ARMED,0,0,0,0,4'b0001,10)); end
    btn4 = 4'b0000;
    for (int r = 0; r < int'(SS4) + 2; r++) tick();
    el = 10 + int'(SS4) + 2;
    checks++; if (obs4 !== exp4(S_ARMED, 0, 0, 0, 0, 4'b0000, el)) begin errors++; $display("FAIL foul_release got=%h want=%h", obs4, exp4(S_ARMED,0,0,0,0,0,el)); end
    btn4 = 4'b0001;
    for (int r = 0; r <= int'(SS4); r++) tick();
    el = el + int'(SS4);
    checks++; if (obs4 !== exp4(S_LOCKED, 1, 0, 4'b0001, 0, 0, el)) begin errors++; $display("FAIL foul_repress got=%h want=%h", obs4, exp4(S_LOCKED,1,0,4'b0001,0,0,el)); end
    end_round_4();
  endtask

  task automatic test_timeout();
    to4 = 16'd5;
    arm_4();
    for (int r = 0; r < 4; r++) tick();
    checks++; if (obs4 !== exp4(S_ARMED, 0, 0, 0, 0, 0, 4)) begin errors++; $display("FAIL to_pre got=%h want=%h", obs4, exp4(S_ARMED,0,0,0,0,0,4)); end
    tick();
    checks++; if (obs4 !== exp4(S_TIMEOUT, 0, 0, 0, 0, 0, 5)) begin errors++; $display("FAIL to_hit got=%h want=%h", obs4, exp4(S_TIMEOUT,0,0,0,0,0,5)); end
    btn4 = 4'b0010;
    for (int r = 0; r < 5; r++) tick();
    checks++; if (obs4 !== exp4(S_TIMEOUT, 0, 0, 0, 0, 0, 5)) begin errors++; $display("FAIL to_press got=%h want=%h", obs4, exp4(S_TIMEOUT,0,0,0,0,0,5)); end
    end_round_4();
    checks++; if (obs4 !== exp4(S_IDLE, 0, 0, 0, 0, 0, 5)) begin errors++; $display("FAIL to_clear got=%h want=%h", obs4, exp4(S_IDLE,0,0,0,0,0,5)); end
    to4 = 16'd0;
    arm_4();
    for (int r = 0; r < 70000; r++) tick();
    checks++; if (obs4 !== exp4(S_ARMED, 0, 0, 0, 0, 0, 16'hFFFF)) begin errors++; $display("FAIL saturate got=%h want=%h", obs4, exp4(S_ARMED,0,0,0,0,0,16'hFFFF)); end
    end_round_4();
  endtask

  task automatic test_collisions();
    int d;
    logic [29:0] held;
    arm4 = 1'b1; clear4 = 1'b1; tick(); arm4 = 1'b0; clear4 = 1'b0;
    checks++; if (state4 !== S_IDLE) begin errors++; $display("FAIL arm_clear state=%0d want=%0d", state4, S_IDLE); end
    tick();
    checks++; if (state4 !== S_IDLE) begin errors++; $display("FAIL arm_clear_next state=%0d want=%0d", state4, S_IDLE); end
    d = 4;
    to4 = 16'(d + 1 + int'(SS4));
    arm_4();
    for (int r = 0; r < d; r++) tick();
    btn4 = 4'b1000;
    for (int r = 0; r <= int'(SS4); r++) tick();
    checks++; if (obs4 !== exp4(S_LOCKED, 1, 3, 4'b1000, 0, 0, d + int'(SS4))) begin errors++; $display("FAIL press_vs_timeout got=%h want=%h", obs4, exp4(S_LOCKED,1,3,4'b1000,0,0,d+int'(SS4))); end
    held = exp4(S_LOCKED, 1, 3, 4'b1000, 0, 0, d + int'(SS4));
    arm_4();
    tick();
    checks++; if (obs4 !== held) begin errors++; $display("FAIL arm_locked got=%h want=%h", obs4, held); end
    to4 = 16'd0;
    end_round_4();
  endtask

  task automatic test_reset_mid();
    arm_4();
    for (int r = 0; r < 3; r++) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (obs4 !== 30'd0) begin errors++; $display("FAIL rst_armed got=%h want=0", obs4); end
    #2 rst = 1'b0;
    tick();
    arm_4();
    btn4 = 4'b0100;
    for (int r = 0; r <= int'(SS4); r++) tick();
    checks++; if (state4 !== S_LOCKED) begin errors++; $display("FAIL rst_prelock state=%0d want=%0d", state4, S_LOCKED); end
    #2 rst = 1'b1;
    #1;
    checks++; if (obs4 !== 30'd0) begin errors++; $display("FAIL rst_locked got=%h want=0", obs4); end
    #2 rst = 1'b0;
    btn4 = '0;
    for (int r = 0; r < int'(SS4) + 2; r++) tick();
  endtask

  task automatic test_wide();
    int d;
    d = 5;
    arm16 = 1'b1; tick(); arm16 = 1'b0;
    for (int r = 0; r < d; r++) tick();
    btn16 = 16'h8000;
    for (int r = 0; r < int'(SS16); r++) tick();
    checks++; if (state16 !== S_ARMED) begin errors++; $display("FAIL wide_prelock state=%0d want=%0d", state16, S_ARMED); end
    tick();
    checks++; if (obs16 !== {S_LOCKED, 1'b1, 4'd15, 16'h8000, 1'b0, 16'h0, 16'(d + int'(SS16))})
      begin errors++; $display("FAIL wide_lock got=%h want=%h", obs16, {S_LOCKED, 1'b1, 4'd15, 16'h8000, 1'b0, 16'h0, 16'(d + int'(SS16))}); end
    btn16 = '0;
  endtask

  task automatic test_random();
    int d, t, lock_rel, fin, low;
    logic [3:0] mask;
    logic [1:0] fin_st;
    logic [29:0] want;
    for (int it = 0; it < 24; it++) begin
      mask = 4'($urandom_range(1, 15));
      d    = int'($urandom_range(0, 15));
      t    = int'($urandom_range(0, 25));
      to4  = 16'(t);
      lock_rel = d + 1 + int'(SS4);
      low = 0;
      for (int b = 3; b >= 0; b--) if (mask[b]) low = b;
      if (t == 0 || lock_rel <= t) begin
        fin = lock_rel; fin_st = S_LOCKED;
        want = exp4(S_LOCKED, 1, 2'(low), 4'(1 << low), ($countones(mask) > 1), 0, d + int'(SS4));
      end else begin
        fin = t; fin_st = S_TIMEOUT;
        want = exp4(S_TIMEOUT, 0, 0, 0, 0, 0, t);
      end
      arm_4();
      for (int r = 1; r <= fin + 2; r++) begin
        if (r - 1 == d) btn4 = mask;
        tick();
        checks++;
        if (state4 !== ((r < fin) ? S_ARMED : fin_st)) begin
          errors++; $display("FAIL rnd_state it=%0d rel=%0d got=%0d want=%0d", it, r, state4, (r < fin) ? S_ARMED : fin_st);
        end
      end
      checks++; if (obs4 !== want) begin errors++; $display("FAIL rnd_final it=%0d got=%h want=%h", it, obs4, want); end
      end_round_4();
    end
    to4 = 16'd0;
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_tie();
    test_foul();
    test_timeout();
    test_collisions();
    test_reset_mid();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
